// File: rtl/sc_stage_ctrl_if.sv
// rtl/sc_stage_ctrl_if.sv - LLR input, partial-sum and result stream bundle for one SC stage
interface sc_stage_ctrl_if #(
    parameter int BITS = 4,
    parameter int LOGN = 2
);
    localparam int N  = 1 << LOGN;
    localparam int IW = (LOGN > 1) ? LOGN - 1 : 1;

    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] in_llr;
    logic            u_valid;
    logic            u_ready;
    logic [N/2-1:0]  u_bits;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out_llr;
    logic            out_is_g;
    logic [IW-1:0]   out_idx;
    logic            done;

    modport master (
        output in_valid, in_llr, u_valid, u_bits, out_ready,
        input  in_ready, u_ready, out_valid, out_llr, out_is_g, out_idx, done
    );

    modport slave (
        input  in_valid, in_llr, u_valid, u_bits, out_ready,
        output in_ready, u_ready, out_valid, out_llr, out_is_g, out_idx, done
    );
endinterface

// File: rtl/sc_stage_ctrl.sv
// rtl/sc_stage_ctrl.sv - SC decoder stage sequencer: buffer N LLRs, emit f results, take u, emit g results
// Optional feature macro SC_G_SAT_EN: saturate the g result instead of wrapping it.
module sc_stage_ctrl #(
    parameter int BITS = 4,
    parameter int LOGN = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    sc_stage_ctrl_if.slave bus
);
    localparam int N  = 1 << LOGN;
    localparam int H  = N / 2;
    localparam int IW = (LOGN > 1) ? LOGN - 1 : 1;
    localparam logic signed [BITS-1:0] SMAX = {1'b0, {(BITS-1){1'b1}}};
    localparam logic signed [BITS-1:0] SMIN = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [LOGN-1:0] LAST_IN  = LOGN'(N - 1);
    localparam logic [LOGN-1:0] LAST_OUT = LOGN'(H - 1);

    typedef enum logic [1:0] {LOAD, F_OUT, WAIT_U, G_OUT} state_t;

    state_t          state;
    logic [LOGN-1:0] cnt;
    logic            in_ready_q;
    logic            u_ready_q;
    logic            out_valid_q;
    logic            out_is_g_q;
    logic            done_q;
    logic [BITS-1:0] llr [N];
    logic [H-1:0]    u_q;

    logic in_fire;
    logic u_fire;
    logic out_fire;

    assign in_fire  = bus.in_valid && in_ready_q;
    assign u_fire   = bus.u_valid && u_ready_q;
    assign out_fire = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            u_ready_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_is_g_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        if (cnt == LAST_IN) begin
                            cnt         <= '0;
                            state       <= F_OUT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_is_g_q  <= 1'b0;
                        end else begin
                            cnt <= cnt + LOGN'(1);
                        end
                    end
                end
                F_OUT: begin
                    if (out_fire) begin
                        if (cnt == LAST_OUT) begin
                            cnt         <= '0;
                            state       <= WAIT_U;
                            out_valid_q <= 1'b0;
                            u_ready_q   <= 1'b1;
                        end else begin
                            cnt <= cnt + LOGN'(1);
                        end
                    end
                end
                WAIT_U: begin
                    if (u_fire) begin
                        state       <= G_OUT;
                        u_ready_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_is_g_q  <= 1'b1;
                    end
                end
                G_OUT: begin
                    if (out_fire) begin
                        if (cnt == LAST_OUT) begin
                            cnt         <= '0;
                            state       <= LOAD;
                            out_valid_q <= 1'b0;
                            out_is_g_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            done_q      <= 1'b1;
                        end else begin
                            cnt <= cnt + LOGN'(1);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Data storage carries no reset; contents are only meaningful after a full load.
    always_ff @(posedge clk) begin
        if (in_fire) llr[cnt] <= bus.in_llr;
        if (u_fire)  u_q      <= bus.u_bits;
    end

    function automatic logic signed [BITS-1:0] sat_abs(input logic signed [BITS-1:0] x);
        if (x == SMIN)
            return SMAX;
        else if (x[BITS-1])
            return -x;
        else
            return x;
    endfunction

    logic [LOGN-1:0]        b_idx;
    logic signed [BITS-1:0] a;
    logic signed [BITS-1:0] b;
    logic signed [BITS-1:0] mag_a;
    logic signed [BITS-1:0] mag_b;
    logic signed [BITS-1:0] m;
    logic signed [BITS-1:0] f_res;
    logic signed [BITS-1:0] g_res;
    logic                   u_sel;

    always_comb begin
        b_idx = cnt + LOGN'(H);
        a     = llr[cnt];
        b     = llr[b_idx];
        mag_a = sat_abs(a);
        mag_b = sat_abs(b);
        m     = (mag_a < mag_b) ? mag_a : mag_b;
        f_res = (a[BITS-1] ^ b[BITS-1]) ? -m : m;
        u_sel = u_q[cnt[IW-1:0]];
    end

`ifdef SC_G_SAT_EN
    localparam logic signed [BITS:0] WMAX = {2'b00, {(BITS-1){1'b1}}};
    localparam logic signed [BITS:0] WMIN = {2'b11, {(BITS-1){1'b0}}};
    logic signed [BITS:0] g_wide;

    always_comb begin
        g_wide = u_sel ? ({b[BITS-1], b} - {a[BITS-1], a})
                       : ({b[BITS-1], b} + {a[BITS-1], a});
        if (g_wide > WMAX)
            g_res = SMAX;
        else if (g_wide < WMIN)
            g_res = SMIN;
        else
            g_res = g_wide[BITS-1:0];
    end
`else
    always_comb begin
        g_res = u_sel ? (b - a) : (b + a);
    end
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.u_ready   = u_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_is_g  = out_is_g_q;
    assign bus.done      = done_q;
    assign bus.out_idx   = out_valid_q ? cnt[IW-1:0] : '0;
    assign bus.out_llr   = !out_valid_q ? '0 : (out_is_g_q ? g_res : f_res);
endmodule

// File: tb/tb_sc_stage_ctrl.sv
// tb/tb_sc_stage_ctrl.sv - randomized self-checking bench for sc_stage_ctrl against a queue-based reference
module tb_sc_stage_ctrl;
    localparam int BITS = 4;
    localparam int LOGN = 2;
    localparam int N    = 1 << LOGN;
    localparam int H    = N / 2;
    localparam int LIM  = 1 << (BITS - 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sc_stage_ctrl_if #(.BITS(BITS), .LOGN(LOGN)) bus();
    sc_stage_ctrl #(.BITS(BITS), .LOGN(LOGN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        bit g;
        int idx;
        int val;
        bit last;
    } exp_t;

    exp_t expq[$];
    int   log_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   done_pend = 0;
    int   done_cnt = 0;
    int   ready_mode = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_mag(input int x);
        if (x == -LIM) return LIM - 1;
        return (x < 0) ? -x : x;
    endfunction

    function automatic int f_ref(input int a, input int b);
        int ma, mb, mm;
        ma = sat_mag(a);
        mb = sat_mag(b);
        mm = (ma < mb) ? ma : mb;
        return ((a < 0) != (b < 0)) ? -mm : mm;
    endfunction

    function automatic int g_ref(input int a, input int b, input bit u);
        int s;
        s = u ? (b - a) : (b + a);
`ifdef SC_G_SAT_EN
        if (s > LIM - 1) s = LIM - 1;
        if (s < -LIM) s = -LIM;
`else
        s = (((s + LIM) % (2 * LIM)) + 2 * LIM) % (2 * LIM) - LIM;
`endif
        return s;
    endfunction

    // Scoreboard: front entry must be presented whenever out_valid is high; pop on accept.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("done_pulse", int'(bus.done), int'(done_pend));
            if (bus.done) done_cnt++;
            done_pend = 0;
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    chk("out_is_g", int'(bus.out_is_g), int'(expq[0].g));
                    chk("out_idx", int'(bus.out_idx), expq[0].idx);
                    chk("out_llr", int'($signed(bus.out_llr)), expq[0].val);
                    if (bus.out_ready) begin
                        log_q.push_back(int'($signed(bus.out_llr)));
                        done_pend = expq[0].last;
                        void'(expq.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    task automatic queue_f(input int v[N]);
        for (int i = 0; i < H; i++) expq.push_back('{g: 1'b0, idx: i, val: f_ref(v[i], v[i+H]), last: 1'b0});
    endtask

    task automatic queue_g(input int v[N], input logic [H-1:0] u);
        for (int i = 0; i < H; i++)
            expq.push_back('{g: 1'b1, idx: i, val: g_ref(v[i], v[i+H], u[i]), last: (i == H - 1)});
    endtask

    task automatic send_llrs(input int v[N], input int count, input bit gaps);
        for (int i = 0; i < count; i++) begin
            bit acc;
            int t;
            acc = 0;
            t = 0;
            while (!acc) begin
                if (gaps && $urandom_range(0, 2) == 0) begin
                    bus.in_valid = 1'b0;
                    bus.in_llr   = BITS'($urandom);
                end else begin
                    bus.in_valid = 1'b1;
                    bus.in_llr   = BITS'(v[i]);
                end
                @(negedge clk);
                acc = bus.in_valid && bus.in_ready;
                @(posedge clk);
                #1;
                t++;
                if (!acc && t > 300) begin
                    chk("in_timeout", 0, 1);
                    acc = 1;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_u(input logic [H-1:0] u, input bit gaps);
        bit acc;
        int t;
        acc = 0;
        t = 0;
        while (!acc) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.u_valid = 1'b0;
                bus.u_bits  = H'($urandom);
            end else begin
                bus.u_valid = 1'b1;
                bus.u_bits  = u;
            end
            @(negedge clk);
            acc = bus.u_valid && bus.u_ready;
            @(posedge clk);
            #1;
            t++;
            if (!acc && t > 300) begin
                chk("u_timeout", 0, 1);
                acc = 1;
            end
        end
        bus.u_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (expq.size() != 0 && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_left", expq.size(), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_stage(input int v[N], input logic [H-1:0] u, input bit gaps);
        done_cnt = 0;
        queue_f(v);
        send_llrs(v, N, gaps);
        queue_g(v, u);
        send_u(u, gaps);
        wait_drain();
        chk("done_count", done_cnt, 1);
    endtask

    initial begin
        int v[N];
        logic [H-1:0] u;
        bus.in_valid = 1'b0;
        bus.in_llr   = '0;
        bus.u_valid  = 1'b0;
        bus.u_bits   = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_u_ready", int'(bus.u_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_is_g", int'(bus.out_is_g), 0);
        chk("rst_out_idx", int'(bus.out_idx), 0);
        chk("rst_out_llr", int'(bus.out_llr), 0);
        chk("rst_done", int'(bus.done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed stage: f = 3, -1; g = 5+3 wraps (or clamps), 1-(-2)
        ready_mode = 0;
        log_q.delete();
        v = '{3, -2, 5, 1};
        run_stage(v, 2'b10, 0);
        chk("t1_log_size", log_q.size(), 4);
        if (log_q.size() >= 4) begin
            chk("t1_f0", log_q[0], 3);
            chk("t1_f1", log_q[1], -1);
`ifdef SC_G_SAT_EN
            chk("t2_g0", log_q[2], 7);
`else
            chk("t2_g0", log_q[2], -8);
`endif
            chk("t2_g1", log_q[3], 3);
        end

        // Saturated magnitude of -8 and zero operands
        log_q.delete();
        v = '{-8, 0, -8, 0};
        run_stage(v, 2'($urandom), 0);
        if (log_q.size() >= 2) begin
            chk("t3_f0", log_q[0], 7);
            chk("t3_f1", log_q[1], 0);
        end else begin
            chk("t3_log_size", log_q.size(), 4);
        end

        // Stall in F_OUT with foreign handshakes toggling
        done_cnt = 0;
        v = '{2, -3, -5, 4};
        queue_f(v);
        send_llrs(v, N, 0);
        ready_mode = 2;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'(i % 2);
            bus.in_llr   = BITS'($urandom);
            bus.u_valid  = 1'((i + 1) % 2);
            bus.u_bits   = H'($urandom);
            @(negedge clk);
            chk("stall_in_ready", int'(bus.in_ready), 0);
            chk("stall_u_ready", int'(bus.u_ready), 0);
            chk("stall_out_valid", int'(bus.out_valid), 1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.u_valid  = 1'b0;
        ready_mode = 0;
        u = 2'b01;
        queue_g(v, u);
        send_u(u, 0);
        wait_drain();
        chk("stall_done_count", done_cnt, 1);

        // Reset after a partial load
        v = '{6, -7, 0, 0};
        send_llrs(v, 2, 0);
        rst_n = 1'b0;
        expq.delete();
        done_pend = 0;
        done_cnt = 0;
        @(negedge clk);
        chk("mid_rst_in_ready", int'(bus.in_ready), 1);
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        chk("mid_rst_done", int'(bus.done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("mid_rst_no_done", done_cnt, 0);
        log_q.delete();
        v = '{1, 1, 1, 1};
        run_stage(v, 2'($urandom), 0);
        if (log_q.size() >= 2) begin
            chk("t5_f0", log_q[0], 1);
            chk("t5_f1", log_q[1], 1);
        end else begin
            chk("t5_log_size", log_q.size(), 4);
        end

        // Random stages with random valid/ready gaps
        ready_mode = 1;
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < N; i++) v[i] = int'($urandom_range(0, 2 * LIM - 1)) - LIM;
            run_stage(v, H'($urandom), 1);
        end
        ready_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
